// File: rtl/pcal6416a_pkg.sv
// Shared definitions for the PCAL6416A target model and its controller:
// register addresses, FSM state encoding and reset values.
package pcal6416a_pkg;

  localparam logic [7:0] REG_IN0    = 8'h00;
  localparam logic [7:0] REG_IN1    = 8'h01;
  localparam logic [7:0] REG_OUT0   = 8'h02;
  localparam logic [7:0] REG_OUT1   = 8'h03;
  localparam logic [7:0] REG_CFG0   = 8'h06;
  localparam logic [7:0] REG_CFG1   = 8'h07;
  localparam logic [7:0] REG_MASK0  = 8'h4A;
  localparam logic [7:0] REG_MASK1  = 8'h4B;
  localparam logic [7:0] REG_ISTAT0 = 8'h4C;
  localparam logic [7:0] REG_ISTAT1 = 8'h4D;

  localparam logic [15:0] RST_PINS_OUT = 16'hFFFF;
  localparam logic [15:0] RST_PINS_DIR = 16'hFFFF;
  localparam logic [15:0] RST_MASK     = 16'hFFFF;
  localparam logic [7:0]  RST_PTR      = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CMD,
    ST_CMD_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  // Auto-increment stays inside the low/high register pair.
  function automatic logic [7:0] pair_next(input logic [7:0] p);
    return {p[7:1], ~p[0]};
  endfunction

endpackage

// File: rtl/pcal6416a_target_line_sync.sv
// Synchronizes raw SCL/SDA and produces single-cycle edge and bus-condition strobes.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_q;
  logic       sda_q;
  logic       scl;

  // Idle bus is high on both lines, so reset the chain to 1 to avoid false edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl_in};
      sda_ff <= {sda_ff[0], sda_in};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
    end
  end

  assign scl      = scl_ff[1];
  assign sda      = sda_ff[1];
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/pcal6416a_target.sv
// I2C target emulating the PCAL6416A 16-bit expander register map.
// SDA output changes are deferred HOLD_CLKS cycles after each SCL fall.
module pcal6416a_target
  import pcal6416a_pkg::*;
#(
  parameter logic [6:0] ADDR      = 7'h20,
  parameter int         HOLD_CLKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] pins_in,
  output logic [15:0] pins_out,
  output logic [15:0] pins_dir,
  output logic        int_n,
  output logic        busy
);

  // state        | meaning
  // ST_IDLE      | not addressed, waiting for START
  // ST_ADDR      | shifting in address + R/W
  // ST_ADDR_ACK  | acknowledging our address
  // ST_CMD       | shifting in the register pointer
  // ST_CMD_ACK   | acknowledging the pointer byte
  // ST_WR_BYTE   | shifting in a write data byte
  // ST_WR_ACK    | acknowledging write data; register updates on this SCL rise
  // ST_RD_BYTE   | shifting out reg[ptr]
  // ST_RD_ACK    | sampling the controller's ACK/NACK
  // ST_WAIT_STOP | read ended with NACK, bus released

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CLKS);

  i2c_state_e  state;
  logic        sda_s, scl_rise, scl_fall, start, stop;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg, ptr, wr_data, rd_byte, hold_cnt;
  logic        rw, got_ack, pend_oe;
  logic [15:0] mask, snap, last_read, status;
  logic [15:0] clr, last_read_nxt, status_nxt;

  i2c_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  always_comb begin
    case (ptr)
      REG_IN0:    rd_byte = snap[7:0];
      REG_IN1:    rd_byte = snap[15:8];
      REG_OUT0:   rd_byte = pins_out[7:0];
      REG_OUT1:   rd_byte = pins_out[15:8];
      REG_CFG0:   rd_byte = pins_dir[7:0];
      REG_CFG1:   rd_byte = pins_dir[15:8];
      REG_MASK0:  rd_byte = mask[7:0];
      REG_MASK1:  rd_byte = mask[15:8];
      REG_ISTAT0: rd_byte = status[7:0];
      REG_ISTAT1: rd_byte = status[15:8];
      default:    rd_byte = 8'h00;
    endcase
  end

  // Change detection uses the post-clear reference so a pin still differing wins over the clear.
  always_comb begin
    clr = '0;
    if (state == ST_RD_ACK && scl_rise) begin
      if (ptr == REG_IN0)
        clr[7:0] = 8'hFF;
      else if (ptr == REG_IN1)
        clr[15:8] = 8'hFF;
    end
    last_read_nxt = (last_read & ~clr) | (snap & clr);
    status_nxt    = (status & ~clr) | ((pins_in ^ last_read_nxt) & ~mask & pins_dir);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_read <= pins_in;
      status    <= '0;
      int_n     <= 1'b1;
    end else begin
      last_read <= last_read_nxt;
      status    <= status_nxt;
      int_n     <= ~|status_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      got_ack  <= 1'b0;
      ptr      <= RST_PTR;
      snap     <= pins_in;
      wr_data  <= '0;
      pins_out <= RST_PINS_OUT;
      pins_dir <= RST_PINS_DIR;
      mask     <= RST_MASK;
      sda_oe   <= 1'b0;
      pend_oe  <= 1'b0;
      hold_cnt <= '0;
      busy     <= 1'b0;
    end else if (stop) begin
      state    <= ST_IDLE;
      sda_oe   <= 1'b0;
      pend_oe  <= 1'b0;
      hold_cnt <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      state    <= ST_ADDR;
      bit_cnt  <= '0;
      sda_oe   <= 1'b0;
      pend_oe  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
        if (hold_cnt == 8'd1)
          sda_oe <= pend_oe;
      end

      if (scl_rise) begin
        case (state)
          ST_ADDR, ST_CMD, ST_WR_BYTE: begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end
          ST_RD_BYTE: bit_cnt <= bit_cnt + 4'd1;
          ST_WR_ACK: begin
            case (ptr)
              REG_OUT0:  pins_out[7:0]  <= wr_data;
              REG_OUT1:  pins_out[15:8] <= wr_data;
              REG_CFG0:  pins_dir[7:0]  <= wr_data;
              REG_CFG1:  pins_dir[15:8] <= wr_data;
              REG_MASK0: mask[7:0]      <= wr_data;
              REG_MASK1: mask[15:8]     <= wr_data;
              default: ;
            endcase
            ptr <= pair_next(ptr);
          end
          ST_RD_ACK: begin
            got_ack <= ~sda_s;
            if (!sda_s)
              ptr <= pair_next(ptr);
          end
          default: ;
        endcase
      end

      if (scl_fall) begin
        case (state)
          ST_ADDR: begin
            if (bit_cnt == 4'd8) begin
              if (shreg[7:1] == ADDR) begin
                state    <= ST_ADDR_ACK;
                rw       <= shreg[0];
                busy     <= 1'b1;
                if (shreg[0])
                  snap <= pins_in;
                pend_oe  <= 1'b1;
                hold_cnt <= HOLD_LD;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_CMD: begin
            if (bit_cnt == 4'd8) begin
              ptr      <= shreg;
              state    <= ST_CMD_ACK;
              pend_oe  <= 1'b1;
              hold_cnt <= HOLD_LD;
            end
          end
          ST_WR_BYTE: begin
            if (bit_cnt == 4'd8) begin
              wr_data  <= shreg;
              state    <= ST_WR_ACK;
              pend_oe  <= 1'b1;
              hold_cnt <= HOLD_LD;
            end
          end
          ST_ADDR_ACK: begin
            bit_cnt  <= '0;
            hold_cnt <= HOLD_LD;
            if (rw) begin
              state   <= ST_RD_BYTE;
              shreg   <= rd_byte;
              pend_oe <= ~rd_byte[7];
            end else begin
              state   <= ST_CMD;
              pend_oe <= 1'b0;
            end
          end
          ST_CMD_ACK, ST_WR_ACK: begin
            bit_cnt  <= '0;
            state    <= ST_WR_BYTE;
            pend_oe  <= 1'b0;
            hold_cnt <= HOLD_LD;
          end
          ST_RD_BYTE: begin
            hold_cnt <= HOLD_LD;
            if (bit_cnt == 4'd8) begin
              state   <= ST_RD_ACK;
              pend_oe <= 1'b0;
            end else begin
              shreg   <= {shreg[6:0], 1'b0};
              pend_oe <= ~shreg[6];
            end
          end
          ST_RD_ACK: begin
            hold_cnt <= HOLD_LD;
            if (got_ack) begin
              state   <= ST_RD_BYTE;
              bit_cnt <= '0;
              shreg   <= rd_byte;
              pend_oe <= ~rd_byte[7];
            end else begin
              state   <= ST_WAIT_STOP;
              pend_oe <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
